// File: rtl/bsg_fsb_murn_boot_sequencer_if.sv
// FSB switch-packet channel: valid/data from the sequencer, ready back from the fabric.
interface bsg_fsb_murn_boot_sequencer_if #(
   parameter int unsigned width_p = 32
);
   logic               v_o;
   logic [width_p-1:0] data_o;
   logic               ready_i;

   modport master (output v_o, output data_o, input ready_i);
   modport slave  (input v_o, input data_o, output ready_i);
endinterface

// File: rtl/bsg_fsb_murn_boot_sequencer.sv
// Boots a range of gateway nodes over FSB: per node, assert reset, release reset,
// idle for a settle period, then enable.
module bsg_fsb_murn_boot_sequencer #(
   parameter int unsigned width_p       = 32,
   parameter int unsigned id_width_p    = 4,
   parameter int unsigned nodes_p       = 4,
   parameter int unsigned node_base_p   = 1,
   parameter int unsigned wait_cycles_p = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic start_i,
   bsg_fsb_murn_boot_sequencer_if.master fsb,
   output logic busy_o,
   output logic done_o
);
   localparam int unsigned idx_w = (nodes_p > 1) ? $clog2(nodes_p) : 1;
   localparam int unsigned cnt_w = $clog2(wait_cycles_p + 1);

   localparam logic [7:0] op_rst   = 8'h03;
   localparam logic [7:0] op_unrst = 8'h04;
   localparam logic [7:0] op_en    = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_RST, S_SEND_UNRST, S_WAIT, S_SEND_EN, S_DONE
   } state_e;

   state_e             state_r, state_n;
   logic [idx_w-1:0]   idx_r, idx_n;
   logic [cnt_w-1:0]   cnt_r, cnt_n;
   logic               v_n, busy_n, done_n;
   logic [width_p-1:0] data_n;
   logic [7:0]         op_n;
   logic [id_width_p-1:0] id_n;
   logic               fire;

   assign fire = fsb.v_o & fsb.ready_i;

   // State and registered outputs; outputs are precomputed from the next state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= S_IDLE;
         idx_r      <= '0;
         cnt_r      <= '0;
         fsb.v_o    <= 1'b0;
         fsb.data_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         state_r    <= state_n;
         idx_r      <= idx_n;
         cnt_r      <= cnt_n;
         fsb.v_o    <= v_n;
         fsb.data_o <= data_n;
         busy_o     <= busy_n;
         done_o     <= done_n;
      end
   end

   // Next-state: sends advance only on transfer; WAIT counts the settle period down.
   always_comb begin
      state_n = state_r;
      idx_n   = idx_r;
      cnt_n   = cnt_r;
      unique case (state_r)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_n = S_SEND_RST;
               idx_n   = '0;
            end
         end
         S_SEND_RST: begin
            if (fire) state_n = S_SEND_UNRST;
         end
         S_SEND_UNRST: begin
            if (fire) begin
               state_n = S_WAIT;
               cnt_n   = cnt_w'(wait_cycles_p);
            end
         end
         S_WAIT: begin
            if (cnt_r <= cnt_w'(1)) begin
               state_n = S_SEND_EN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_r - cnt_w'(1);
            end
         end
         S_SEND_EN: begin
            if (fire) begin
               if (idx_r == idx_w'(nodes_p - 1)) begin
                  state_n = S_DONE;
               end else begin
                  idx_n   = idx_r + idx_w'(1);
                  state_n = S_SEND_RST;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Output decode of the next state; node id wraps within id_width_p bits.
   always_comb begin
      v_n    = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      op_n   = 8'h00;
      data_n = '0;
      id_n   = id_width_p'(node_base_p + 32'(idx_n));
      unique case (state_n)
         S_SEND_RST:   begin v_n = 1'b1; busy_n = 1'b1; op_n = op_rst;   end
         S_SEND_UNRST: begin v_n = 1'b1; busy_n = 1'b1; op_n = op_unrst; end
         S_SEND_EN:    begin v_n = 1'b1; busy_n = 1'b1; op_n = op_en;    end
         S_WAIT:       busy_n = 1'b1;
         S_DONE:       done_n = 1'b1;
         default:      ;
      endcase
      if (v_n) begin
         data_n[width_p-1 -: id_width_p]  = id_n;
         data_n[width_p-1-id_width_p]     = 1'b1;
         data_n[7:0]                      = op_n;
      end
   end
endmodule

// File: tb/tb_bsg_fsb_murn_boot_sequencer.sv
// Two sequencers (node_base 1 and 14) on shared stimulus, checked against a
// packet-count model every cycle plus literal expectations for directed scenarios.
module tb_bsg_fsb_murn_boot_sequencer;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ready = 1'b1;
   logic busy0, done0, busy1, done1;

   always #5 clk = ~clk;

   bsg_fsb_murn_boot_sequencer_if #(.width_p(32)) f0 ();
   bsg_fsb_murn_boot_sequencer_if #(.width_p(32)) f1 ();
   assign f0.ready_i = ready;
   assign f1.ready_i = ready;

   bsg_fsb_murn_boot_sequencer dut0 (
      .clk_i(clk), .reset_i(rst), .start_i(start), .fsb(f0), .busy_o(busy0), .done_o(done0)
   );
   bsg_fsb_murn_boot_sequencer #(.node_base_p(14)) dut1 (
      .clk_i(clk), .reset_i(rst), .start_i(start), .fsb(f1), .busy_o(busy1), .done_o(done1)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a sequence is a list of 3*N packets; k indexes the next one, gap is the settle idle time.
   int  m_base [2] = '{1, 14};
   bit  m_active [2];
   bit  m_done [2];
   int  m_k [2];
   int  m_gap [2];
   bit  armed = 1'b0;

   function automatic logic [31:0] pkt(input int base, input int k);
      int id;
      logic [7:0] op;
      id = (base + k / 3) % 16;
      case (k % 3)
         0: op = 8'h03;
         1: op = 8'h04;
         default: op = 8'h01;
      endcase
      return (32'(id) << 28) | 32'h0800_0000 | 32'(op);
   endfunction

   always @(posedge clk) begin
      armed <= 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_active[i] <= 1'b0; m_done[i] <= 1'b0; m_k[i] <= 0; m_gap[i] <= 0;
         end else if (!m_active[i]) begin
            if (start) begin
               m_active[i] <= 1'b1; m_done[i] <= 1'b0; m_k[i] <= 0; m_gap[i] <= 0;
            end
         end else if (m_gap[i] > 0) begin
            m_gap[i] <= m_gap[i] - 1;
         end else if (ready) begin
            if (m_k[i] % 3 == 1) m_gap[i] <= W;
            if (m_k[i] == 3 * N - 1) begin
               m_active[i] <= 1'b0; m_done[i] <= 1'b1; m_k[i] <= 0;
            end else begin
               m_k[i] <= m_k[i] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            bit ev;
            logic av, ab, ad;
            logic [31:0] adata;
            ev    = m_active[i] && (m_gap[i] == 0);
            av    = (i == 0) ? f0.v_o : f1.v_o;
            ab    = (i == 0) ? busy0 : busy1;
            ad    = (i == 0) ? done0 : done1;
            adata = (i == 0) ? f0.data_o : f1.data_o;
            chk($sformatf("model_v%0d", i), 32'(av), 32'(ev));
            chk($sformatf("model_busy%0d", i), 32'(ab), 32'(m_active[i]));
            chk($sformatf("model_done%0d", i), 32'(ad), 32'(m_done[i]));
            if (ev) chk($sformatf("model_data%0d", i), adata, pkt(m_base[i], m_k[i]));
         end
      end
   end

   logic [31:0] log0[$];
   logic [31:0] log1[$];
   always @(posedge clk) begin
      if (!rst) begin
         if (f0.v_o && ready) log0.push_back(f0.data_o);
         if (f1.v_o && ready) log1.push_back(f1.data_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_pkt(input logic [31:0] d);
      int c = 0;
      while (!(f0.v_o && f0.data_o == d) && c < 400) begin
         tick();
         c++;
      end
      chk("reach_pkt_v", 32'(f0.v_o), 32'd1);
      chk("reach_pkt_data", f0.data_o, d);
   endtask

   task automatic wait_done();
      int c = 0;
      while (!done0 && c < 400) begin
         tick();
         c++;
      end
      chk("reach_done", 32'(done0), 32'd1);
   endtask

   logic [31:0] exp0 [12] = '{
      32'h18000003, 32'h18000004, 32'h18000001, 32'h28000003, 32'h28000004, 32'h28000001,
      32'h38000003, 32'h38000004, 32'h38000001, 32'h48000003, 32'h48000004, 32'h48000001};
   logic [31:0] exp1 [12] = '{
      32'hE8000003, 32'hE8000004, 32'hE8000001, 32'hF8000003, 32'hF8000004, 32'hF8000001,
      32'h08000003, 32'h08000004, 32'h08000001, 32'h18000003, 32'h18000004, 32'h18000001};

   initial begin
      int n;
      logic [31:0] a;

      repeat (3) tick();
      chk("rst_v", 32'(f0.v_o), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      rst = 1'b0;
      tick();

      // Clean run with ready held high.
      log0.delete(); log1.delete();
      pulse_start();
      chk("first_v", 32'(f0.v_o), 32'd1);
      chk("first_pkt0", f0.data_o, 32'h18000003);
      chk("first_pkt1", f1.data_o, 32'hE8000003);
      n = 0;
      for (int c = 0; c < 200 && !done0; c++) begin
         if (busy0) n++;
         tick();
      end
      chk("run_done", 32'(done0), 32'd1);
      chk("run_busy_end", 32'(busy0), 32'd0);
      chk("run_busy_cycles", 32'(n), 32'd44);
      chk("run_count0", 32'(log0.size()), 32'd12);
      chk("run_count1", 32'(log1.size()), 32'd12);
      for (int k = 0; k < 12; k++) begin
         a = (k < log0.size()) ? log0[k] : 32'hDEADDEAD;
         chk($sformatf("run_pkt0_%0d", k), a, exp0[k]);
         a = (k < log1.size()) ? log1[k] : 32'hDEADDEAD;
         chk($sformatf("run_pkt1_%0d", k), a, exp1[k]);
      end

      // Rerun from DONE, ignored start during WAIT, and a 5-cycle stall on node 2 release.
      log0.delete(); log1.delete();
      pulse_start();
      chk("rerun_done_clear", 32'(done0), 32'd0);
      chk("rerun_done_clear1", 32'(done1), 32'd0);
      wait_pkt(32'h18000004);
      tick();
      pulse_start();
      chk("wait_start_ignored_v", 32'(f0.v_o), 32'd0);
      chk("wait_start_ignored_busy", 32'(busy0), 32'd1);
      wait_pkt(32'h28000004);
      ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("stall_v", 32'(f0.v_o), 32'd1);
         chk("stall_data", f0.data_o, 32'h28000004);
      end
      ready = 1'b1;
      tick();
      chk("post_stall_v", 32'(f0.v_o), 32'd0);
      wait_done();
      chk("rerun_count0", 32'(log0.size()), 32'd12);

      // Reset during a stalled node 3 enable, with start asserted alongside reset.
      pulse_start();
      wait_pkt(32'h38000001);
      ready = 1'b0;
      tick(); tick();
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("abort_v", 32'(f0.v_o), 32'd0);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      tick();
      chk("abort_idle_v", 32'(f0.v_o), 32'd0);
      ready = 1'b1;
      pulse_start();
      chk("restart_pkt", f0.data_o, 32'h18000003);
      wait_done();

      // Random traffic: backpressure, stray starts, occasional resets.
      for (int c = 0; c < 3000; c++) begin
         ready = ($urandom % 4) != 0;
         start = ($urandom % 25) == 0;
         rst   = ($urandom % 400) == 0;
         tick();
      end
      rst = 1'b0; start = 1'b0; ready = 1'b1;
      repeat (60) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bsg_fsb_murn_boot_sequencer.md
BSG_FSB_MURN_BOOT_SEQUENCER -- requirements
Module: bsg_fsb_murn_boot_sequencer

Interface
REQ-001 Parameter: width_p, default 32, FSB packet width in bits.
REQ-002 Parameter: id_width_p, default 4, destination node id field width.
REQ-003 Parameter: nodes_p, default 4, number of gateway nodes sequenced, ids node_base_p..node_base_p+nodes_p-1.
REQ-004 Parameter: node_base_p, default 1, id of first node.
REQ-005 Parameter: wait_cycles_p, default 8, idle cycles between reset deassert and enable per node (>=1).
REQ-006 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 start_i  input  1  single-cycle request to begin boot sequence.
REQ-009 v_o  output  1  outgoing switch packet valid.
REQ-010 data_o  output  width_p  outgoing switch packet.
REQ-011 ready_i  input  1  downstream FSB accepts packet; transfer when v_o & ready_i.
REQ-012 busy_o  output  1  sequence in progress.
REQ-013 done_o  output  1  sequence completed; sticky until next accepted start_i or reset.

Function
REQ-014 Packet: data_o[width_p-1 -: id_width_p] = dest id; bit [width_p-1-id_width_p] = 1 (switch cmd); bits [7:0] = opcode; all other bits 0.
REQ-015 Opcodes: 0x03 assert node reset, 0x04 deassert node reset, 0x01 enable node.
REQ-016 States: IDLE, SEND_RST, SEND_UNRST, WAIT, SEND_EN, DONE.
REQ-017 IDLE or DONE, start_i=1 -> SEND_RST, node index 0, done_o cleared next cycle.
REQ-018 start_i while busy_o=1 is ignored, no effect on sequence.
REQ-019 v_o=1 exactly in SEND_RST, SEND_UNRST, SEND_EN; 0 in all other states.
REQ-020 data_o stable while v_o=1 and ready_i=0; v_o never withdrawn before transfer.
REQ-021 SEND_RST transfer -> SEND_UNRST; SEND_UNRST transfer -> WAIT, counter loaded wait_cycles_p.
REQ-022 WAIT decrements each cycle; exactly wait_cycles_p cycles with v_o=0, then SEND_EN.
REQ-023 SEND_EN transfer: index < nodes_p-1 -> index+1, SEND_RST; index = nodes_p-1 -> DONE.
REQ-024 Node id = node_base_p + index, truncated to id_width_p bits (wrap-around permitted, no error).
REQ-025 First v_o assertion one cycle after start_i accepted; back-to-back transfers when ready_i held 1.
REQ-026 busy_o=1 in SEND_RST, SEND_UNRST, WAIT, SEND_EN; done_o=1 only in DONE.
REQ-027 Total packets per sequence = 3*nodes_p, order per node: 0x03, 0x04, 0x01.
REQ-028 ready_i while v_o=0 has no effect.

Reset
REQ-029 reset_i=1 at any cycle, including mid-sequence or mid-stall -> IDLE next edge, index and counter 0.
REQ-030 Reset values: v_o=0, busy_o=0, done_o=0; data_o don't-care while v_o=0.
REQ-031 Reset dominates start_i in same cycle; no packet issued from a sequence aborted by reset.

Verification
REQ-032 Defaults, ready_i=1, start_i pulse -> 12 packets ids 1,1,1,2,2,2,...,4, opcodes 03,04,01 repeating, 8 idle cycles after each 0x04, then done_o=1, busy_o=0.
REQ-033 ready_i=0 for 5 cycles during node 2 SEND_UNRST -> v_o held, data_o=id 2/opcode 0x04 constant, transfer on first ready_i=1.
REQ-034 start_i pulsed during WAIT of node 1 -> ignored; sequence still emits exactly 12 packets.
REQ-035 reset_i during node 3 SEND_EN stall -> next cycle v_o=0, busy_o=0, done_o=0; new start_i restarts from node 1 opcode 0x03.
REQ-036 node_base_p=14, id_width_p=4, nodes_p=4 -> ids 14,15,0,1 (wrap); done_o then second start_i clears done_o and reruns.
